// File: rtl/gsau_ctrl_mc.sv
// GSAU control: pairs scoreboard instructions with veggie operands, issues to the SA,
// tracks destinations in order and buffers SA results for writeback under credit control.
// Ports: CLK/RST (sync, active-high), flush; sb_* instruction handshake; veg_* operand
// handshake; sa_in_* issue to SA (sa_fifo_has_space back-pressure); sa_out_en/
// sa_array_output unstallable results; wb_* writeback handshake; credits, busy, err_orphan.
// Optional GSAU_PERF_CNT_EN adds perf_issued, perf_credit_stall, perf_sa_stall, perf_wb_stall.
module gsau_ctrl_mc #(
    parameter int DATA_W = 512,
    parameter int VREG_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       sb_valid,
    output logic                       sb_ready,
    input  logic [VREG_W-1:0]          sb_vdst,
    input  logic                       sb_weight,
    input  logic                       veg_valid,
    output logic                       veg_ready,
    input  logic [DATA_W-1:0]          veg_vdata,
    input  logic                       sa_fifo_has_space,
    output logic                       sa_in_valid,
    output logic                       sa_in_weight,
    output logic [DATA_W-1:0]          sa_in_data,
    input  logic                       sa_out_en,
    input  logic [DATA_W-1:0]          sa_array_output,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [VREG_W-1:0]          wb_wbdst,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]     credits,
    output logic                       busy,
    output logic                       err_orphan
`ifdef GSAU_PERF_CNT_EN
    ,
    output logic [31:0]                perf_issued,
    output logic [31:0]                perf_credit_stall,
    output logic [31:0]                perf_sa_stall,
    output logic [31:0]                perf_wb_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, HAVE_INSTR, HAVE_DATA, READY} state_e;

    state_e                     state_q, state_d;
    logic [VREG_W-1:0]          vdst_q;
    logic                       weight_q;
    logic [DATA_W-1:0]          data_q;
    logic [CW-1:0]              credits_q, credits_d;
    logic                       err_orphan_q, err_orphan_d;

    logic [VREG_W-1:0]          dq_mem [DEPTH];
    logic [AW-1:0]              dq_wp_q, dq_wp_d, dq_rp_q, dq_rp_d;
    logic [CW-1:0]              dq_cnt_q, dq_cnt_d;

    logic [VREG_W+DATA_W-1:0]   of_mem [DEPTH];
    logic [AW-1:0]              of_wp_q, of_wp_d, of_rp_q, of_rp_d;
    logic [CW-1:0]              of_cnt_q, of_cnt_d;

    logic sb_hs, veg_hs, issue, comp_issue;
    logic dq_push, dq_pop, of_push, of_pop;

    assign sb_ready  = (state_q == IDLE) || (state_q == HAVE_DATA);
    assign veg_ready = (state_q == IDLE) || (state_q == HAVE_INSTR);
    assign sb_hs     = sb_valid && sb_ready;
    assign veg_hs    = veg_valid && veg_ready;

    // Weight loads need no output slot, so only compute waits on credits.
    assign issue      = (state_q == READY) && sa_fifo_has_space && !flush &&
                        (weight_q || (credits_q != '0));
    assign comp_issue = issue && !weight_q;

    assign dq_push = comp_issue;
    assign dq_pop  = sa_out_en && (dq_cnt_q != '0) && !flush;
    assign of_push = dq_pop;
    assign wb_valid = (of_cnt_q != '0);
    assign of_pop  = wb_valid && wb_ready && !flush;

    assign sa_in_valid  = issue;
    assign sa_in_weight = issue ? weight_q : 1'b0;
    assign sa_in_data   = issue ? data_q : '0;

    assign wb_wbdst = wb_valid ? of_mem[of_rp_q][VREG_W+DATA_W-1:DATA_W] : '0;
    assign wb_data  = wb_valid ? of_mem[of_rp_q][DATA_W-1:0] : '0;

    assign credits    = credits_q;
    assign err_orphan = err_orphan_q;
    assign busy       = (state_q != IDLE) || (dq_cnt_q != '0) || (of_cnt_q != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sb_hs && veg_hs) state_d = READY;
                else if (sb_hs)      state_d = HAVE_INSTR;
                else if (veg_hs)     state_d = HAVE_DATA;
            end
            HAVE_INSTR: if (veg_hs) state_d = READY;
            HAVE_DATA:  if (sb_hs)  state_d = READY;
            READY:      if (issue)  state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        dq_wp_d  = dq_wp_q + AW'(dq_push);
        dq_rp_d  = dq_rp_q + AW'(dq_pop);
        dq_cnt_d = dq_cnt_q + CW'(dq_push) - CW'(dq_pop);
        of_wp_d  = of_wp_q + AW'(of_push);
        of_rp_d  = of_rp_q + AW'(of_pop);
        of_cnt_d = of_cnt_q + CW'(of_push) - CW'(of_pop);
        credits_d = credits_q - CW'(comp_issue) + CW'(of_pop);
        err_orphan_d = err_orphan_q | (sa_out_en && (dq_cnt_q == '0) && !flush);
        if (flush) begin
            dq_wp_d   = '0;
            dq_rp_d   = '0;
            dq_cnt_d  = '0;
            of_wp_d   = '0;
            of_rp_d   = '0;
            of_cnt_d  = '0;
            credits_d = CW'(DEPTH);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            credits_q    <= CW'(DEPTH);
            err_orphan_q <= 1'b0;
            dq_wp_q      <= '0;
            dq_rp_q      <= '0;
            dq_cnt_q     <= '0;
            of_wp_q      <= '0;
            of_rp_q      <= '0;
            of_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            err_orphan_q <= err_orphan_d;
            dq_wp_q      <= dq_wp_d;
            dq_rp_q      <= dq_rp_d;
            dq_cnt_q     <= dq_cnt_d;
            of_wp_q      <= of_wp_d;
            of_rp_q      <= of_rp_d;
            of_cnt_q     <= of_cnt_d;
        end
    end

    // Payload storage carries no reset; outputs are gated by valid state.
    always_ff @(posedge CLK) begin
        if (sb_hs) begin
            vdst_q   <= sb_vdst;
            weight_q <= sb_weight;
        end
        if (veg_hs) data_q <= veg_vdata;
        if (dq_push) dq_mem[dq_wp_q] <= vdst_q;
        if (of_push) of_mem[of_wp_q] <= {dq_mem[dq_rp_q], sa_array_output};
    end

`ifdef GSAU_PERF_CNT_EN
    logic [31:0] pi_q, pc_q, ps_q, pw_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pi_q <= '0;
            pc_q <= '0;
            ps_q <= '0;
            pw_q <= '0;
        end else begin
            if (issue && pi_q != '1) pi_q <= pi_q + 32'd1;
            if (state_q == READY && !weight_q && credits_q == '0 && pc_q != '1)
                pc_q <= pc_q + 32'd1;
            if (state_q == READY && !sa_fifo_has_space && ps_q != '1)
                ps_q <= ps_q + 32'd1;
            if (wb_valid && !wb_ready && pw_q != '1) pw_q <= pw_q + 32'd1;
        end
    end

    assign perf_issued       = pi_q;
    assign perf_credit_stall = pc_q;
    assign perf_sa_stall     = ps_q;
    assign perf_wb_stall     = pw_q;
`endif

endmodule

// File: tb/tb_gsau_ctrl_mc.sv
// Directed self-checking bench for gsau_ctrl_mc.
// Scoreboard queues hold expected destinations and writebacks.
module tb_gsau_ctrl_mc;

    localparam int DATA_W = 512;
    localparam int VREG_W = 8;
    localparam int DEPTH  = 8;
    localparam int XW     = 576;

    logic              CLK = 1'b0;
    logic              RST, flush;
    logic              sb_valid, sb_ready, sb_weight;
    logic [VREG_W-1:0] sb_vdst;
    logic              veg_valid, veg_ready;
    logic [DATA_W-1:0] veg_vdata;
    logic              sa_fifo_has_space, sa_in_valid, sa_in_weight;
    logic [DATA_W-1:0] sa_in_data;
    logic              sa_out_en;
    logic [DATA_W-1:0] sa_array_output;
    logic              wb_valid, wb_ready;
    logic [VREG_W-1:0] wb_wbdst;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        credits;
    logic              busy, err_orphan;

    int checks = 0;
    int failures = 0;
    logic [VREG_W-1:0]        exp_dst[$];
    logic [VREG_W+DATA_W-1:0] exp_wb[$];
    logic                     issued9;

    gsau_ctrl_mc #(.DATA_W(DATA_W), .VREG_W(VREG_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .sb_valid(sb_valid), .sb_ready(sb_ready), .sb_vdst(sb_vdst),
        .sb_weight(sb_weight),
        .veg_valid(veg_valid), .veg_ready(veg_ready), .veg_vdata(veg_vdata),
        .sa_fifo_has_space(sa_fifo_has_space), .sa_in_valid(sa_in_valid),
        .sa_in_weight(sa_in_weight), .sa_in_data(sa_in_data),
        .sa_out_en(sa_out_en), .sa_array_output(sa_array_output),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wbdst(wb_wbdst),
        .wb_data(wb_data), .credits(credits), .busy(busy),
        .err_orphan(err_orphan)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [XW-1:0] obs,
                       input logic [XW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present instruction and/or data for one edge, then settle.
    task automatic hs(input logic sb, input logic vg, input logic [7:0] d,
                      input logic w, input logic [DATA_W-1:0] data);
        sb_valid = sb;
        veg_valid = vg;
        sb_vdst = d;
        sb_weight = w;
        veg_vdata = data;
        if (sb && !w) exp_dst.push_back(d);
        tick();
        sb_valid = 1'b0;
        veg_valid = 1'b0;
        #1;
    endtask

    task automatic expect_issue(input string tag, input logic [DATA_W-1:0] data,
                                input logic w);
        chk({tag, "_valid"}, XW'(sa_in_valid), XW'(1'b1));
        chk({tag, "_data"}, XW'(sa_in_data), XW'(data));
        chk({tag, "_weight"}, XW'(sa_in_weight), XW'(w));
        tick();
        chk({tag, "_pulse_end"}, XW'(sa_in_valid), XW'(1'b0));
    endtask

    task automatic result(input logic [DATA_W-1:0] data);
        logic [VREG_W-1:0] d;
        d = (exp_dst.size() > 0) ? exp_dst.pop_front() : '0;
        exp_wb.push_back({d, data});
        sa_out_en = 1'b1;
        sa_array_output = data;
        tick();
        sa_out_en = 1'b0;
        #1;
    endtask

    task automatic wb_take(input string tag);
        logic [VREG_W+DATA_W-1:0] e;
        chk({tag, "_wbvalid"}, XW'(wb_valid), XW'(1'b1));
        e = (exp_wb.size() > 0) ? exp_wb.pop_front() : '1;
        chk({tag, "_wbhead"}, XW'({wb_wbdst, wb_data}), XW'(e));
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        #1;
    endtask

    initial begin
        RST = 1'b1; flush = 1'b0;
        sb_valid = 1'b0; sb_vdst = '0; sb_weight = 1'b0;
        veg_valid = 1'b0; veg_vdata = '0;
        sa_fifo_has_space = 1'b0; sa_out_en = 1'b0; sa_array_output = '0;
        wb_ready = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tick();

        // Reset in the middle of a pending issue
        hs(1'b1, 1'b1, 8'h11, 1'b0, 512'hDEAD);
        tick();
        RST = 1'b1;
        tick(); tick(); tick();
        RST = 1'b0;
        #1;
        exp_dst.delete();
        chk("rst_sa_in_valid", XW'(sa_in_valid), XW'(1'b0));
        chk("rst_sa_in_weight", XW'(sa_in_weight), XW'(1'b0));
        chk("rst_sa_in_data", XW'(sa_in_data), XW'(0));
        chk("rst_wb_valid", XW'(wb_valid), XW'(1'b0));
        chk("rst_wb_wbdst", XW'(wb_wbdst), XW'(0));
        chk("rst_wb_data", XW'(wb_data), XW'(0));
        chk("rst_busy", XW'(busy), XW'(1'b0));
        chk("rst_sb_ready", XW'(sb_ready), XW'(1'b1));
        chk("rst_veg_ready", XW'(veg_ready), XW'(1'b1));
        chk("rst_credits", XW'(credits), XW'(DEPTH));
        chk("rst_err_orphan", XW'(err_orphan), XW'(1'b0));

        // Basic transaction
        sa_fifo_has_space = 1'b1;
        hs(1'b1, 1'b1, 8'h42, 1'b0, 512'hCAFEBABE);
        expect_issue("basic", 512'hCAFEBABE, 1'b0);
        chk("basic_credits7", XW'(credits), XW'(7));
        chk("basic_busy", XW'(busy), XW'(1'b1));
        result(512'h1234);
        wb_take("basic");
        chk("basic_credits8", XW'(credits), XW'(8));
        chk("basic_wb_empty", XW'(wb_valid), XW'(1'b0));

        // Data first (HAVE_DATA path)
        hs(1'b0, 1'b1, 8'h00, 1'b0, 512'hD1D1);
        chk("hd_sb_ready", XW'(sb_ready), XW'(1'b1));
        chk("hd_veg_ready", XW'(veg_ready), XW'(1'b0));
        tick(); tick(); tick(); tick();
        chk("hd_no_issue", XW'(sa_in_valid), XW'(1'b0));
        hs(1'b1, 1'b0, 8'h03, 1'b0, '0);
        expect_issue("hd", 512'hD1D1, 1'b0);
        result(512'hA3);
        wb_take("hd");

        // Instruction first (HAVE_INSTR path)
        hs(1'b1, 1'b0, 8'h04, 1'b0, '0);
        chk("hi_sb_ready", XW'(sb_ready), XW'(1'b0));
        chk("hi_veg_ready", XW'(veg_ready), XW'(1'b1));
        tick();
        hs(1'b0, 1'b1, 8'h00, 1'b0, 512'hD2D2);
        expect_issue("hi", 512'hD2D2, 1'b0);
        result(512'hA4);
        wb_take("hi");

        // Credit exhaustion with writeback stalled
        for (int i = 0; i < 8; i++) begin
            hs(1'b1, 1'b1, 8'(i), 1'b0, 512'(100 + i));
            expect_issue("cr", 512'(100 + i), 1'b0);
            result(512'(32'h500 + i));
        end
        hs(1'b1, 1'b1, 8'd8, 1'b0, 512'd108);
        chk("cr_blocked", XW'(sa_in_valid), XW'(1'b0));
        chk("cr_zero", XW'(credits), XW'(0));
        chk("cr_wbvalid", XW'(wb_valid), XW'(1'b1));
        tick(); tick();
        chk("cr_still_blocked", XW'(sa_in_valid), XW'(1'b0));
        chk("cr_sb_ready", XW'(sb_ready), XW'(1'b0));
        issued9 = 1'b0;
        wb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [VREG_W+DATA_W-1:0] e;
            chk("drain_valid", XW'(wb_valid), XW'(1'b1));
            e = (exp_wb.size() > 0) ? exp_wb.pop_front() : '1;
            chk("drain_head", XW'({wb_wbdst, wb_data}), XW'(e));
            if (sa_in_valid) begin
                chk("drain_issue9", XW'(sa_in_data), XW'(108));
                issued9 = 1'b1;
            end
            tick();
        end
        wb_ready = 1'b0;
        #1;
        chk("cr_issued9", XW'(issued9), XW'(1'b1));
        chk("cr_credits7", XW'(credits), XW'(7));
        result(512'h508);
        wb_take("cr9");
        chk("cr_credits8", XW'(credits), XW'(8));

        // Weight load produces no destination; result is an orphan
        hs(1'b1, 1'b1, 8'h77, 1'b1, 512'hBEEF);
        expect_issue("wt", 512'hBEEF, 1'b1);
        chk("wt_credits", XW'(credits), XW'(8));
        chk("wt_busy", XW'(busy), XW'(1'b0));
        sa_out_en = 1'b1;
        sa_array_output = 512'h99;
        tick();
        sa_out_en = 1'b0;
        #1;
        chk("wt_orphan", XW'(err_orphan), XW'(1'b1));
        chk("wt_no_wb", XW'(wb_valid), XW'(1'b0));
        chk("wt_busy2", XW'(busy), XW'(1'b0));

        // Flush with buffered results and a concurrent SA output
        for (int i = 0; i < 4; i++) begin
            hs(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 512'(200 + i));
            expect_issue("fl", 512'(200 + i), 1'b0);
        end
        for (int i = 0; i < 3; i++) result(512'(300 + i));
        chk("fl_credits4", XW'(credits), XW'(4));
        flush = 1'b1;
        sa_out_en = 1'b1;
        sa_array_output = 512'h303;
        tick();
        flush = 1'b0;
        sa_out_en = 1'b0;
        #1;
        exp_dst.delete();
        exp_wb.delete();
        chk("fl_wb_valid", XW'(wb_valid), XW'(1'b0));
        chk("fl_credits", XW'(credits), XW'(8));
        chk("fl_busy", XW'(busy), XW'(1'b0));
        chk("fl_orphan_kept", XW'(err_orphan), XW'(1'b1));
        chk("fl_sb_ready", XW'(sb_ready), XW'(1'b1));

        // Normal operation resumes after flush
        hs(1'b1, 1'b1, 8'h5A, 1'b0, 512'h777);
        expect_issue("pf", 512'h777, 1'b0);
        result(512'h888);
        wb_take("pf");
        chk("pf_credits", XW'(credits), XW'(8));

        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rst_clears_orphan", XW'(err_orphan), XW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gsau_ctrl_mc.md
Name: gsau_ctrl_mc

Overview:
Parametrised next-generation GSAU control unit. It pairs scoreboard instructions with veggie-register operand data and issues them to the systolic array (SA). It tracks destination registers in order through a read-destination queue, and buffers SA results in an output FIFO for writeback. Credit-based throttling guarantees that an SA output, which cannot be stalled, always has buffer space. The block sits between the scoreboard/veggie file and the SA on the input side, and between the SA and the writeback arbiter on the output side.

Parameters:
DATA_W, 512, width of operand and result vectors.
VREG_W, 8, destination register index width (256 veggie registers).
DEPTH, 8, depth of the read-destination queue and of the output FIFO; also the initial credit count; power of two, at least 2.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous reset, active-high.
flush  in  1  synchronous flush of all pipeline state.
sb_valid  in  1  scoreboard instruction valid.
sb_ready  out  1  instruction accepted when sb_valid and sb_ready are both high.
sb_vdst  in  VREG_W  destination register.
sb_weight  in  1  1 = weight-load (no result), 0 = compute.
veg_valid  in  1  operand data valid.
veg_ready  out  1  data accepted when veg_valid and veg_ready are both high.
veg_vdata  in  DATA_W  operand vector.
sa_fifo_has_space  in  1  SA input can take one vector this cycle.
sa_in_valid  out  1  one-cycle issue pulse to SA.
sa_in_weight  out  1  mode bit of the issued vector.
sa_in_data  out  DATA_W  issued vector.
sa_out_en  in  1  SA result valid (not stallable).
sa_array_output  in  DATA_W  SA result.
wb_valid  out  1  writeback request.
wb_ready  in  1  writeback accepts when wb_valid and wb_ready are both high.
wb_wbdst  out  VREG_W  destination register of the head result.
wb_data  out  DATA_W  head result.
credits  out  $clog2(DEPTH)+1  free output slots.
busy  out  1  any instruction held, queued, or buffered.
err_orphan  out  1  sticky: SA output arrived with the destination queue empty.

Behaviour:
- Reset (RST high at a CLK edge): FSM goes to IDLE; queues are emptied; credits = DEPTH; err_orphan = 0.
- Reset values of outputs: sa_in_valid = 0; sa_in_weight = 0; sa_in_data = 0; wb_valid = 0; wb_wbdst = 0; wb_data = 0; busy = 0; sb_ready = 1; veg_ready = 1.
- Reset takes effect mid-operation, regardless of any other input.
- Issue FSM states: IDLE, HAVE_INSTR, HAVE_DATA, READY.
  - IDLE: sb_ready = veg_ready = 1. Both handshakes in one cycle -> READY. Instruction only -> HAVE_INSTR. Data only -> HAVE_DATA.
  - HAVE_INSTR: sb_ready = 0, veg_ready = 1. Data handshake -> READY.
  - HAVE_DATA: veg_ready = 0, sb_ready = 1. Instruction handshake -> READY.
  - READY: sb_ready = veg_ready = 0.
- Issue condition in READY: sa_fifo_has_space = 1 AND (weight = 1 OR credits > 0). When met:
  - sa_in_valid pulses for exactly one cycle with the held data and mode.
  - Compute instructions push vdst into the destination queue and decrement credits.
  - FSM returns to IDLE.
- Minimum latency: handshake at edge N -> sa_in_valid high in cycle N+1.
- No bypass: a new instruction is accepted only in the cycle after the FSM re-enters IDLE.
- Result path: sa_out_en at edge N pops the destination queue head and pushes {vdst, sa_array_output} into the output FIFO. If the output FIFO was empty, wb_valid = 1 in cycle N+1.
- wb_valid = output FIFO not empty; wb_wbdst and wb_data show the FIFO head.
- A writeback handshake pops the head and increments credits.
- An issue and a writeback handshake in the same cycle leave credits unchanged.
- Credits ensure the output FIFO never overflows and the destination queue never overflows.
- Push and pop on the same cycle are both legal; pointers wrap modulo DEPTH.
- sa_out_en with the destination queue empty: err_orphan is set, the result is dropped, and no FIFO changes occur.
- Weight-load instructions never produce a destination entry.
- flush: clears the FSM, both queues, and credits (back to DEPTH) in one cycle.
  - flush outranks every same-cycle event: no issue, and any sa_out_en that cycle is dropped without raising err_orphan.
  - flush does not clear err_orphan; only RST does.
- busy = (FSM not IDLE) OR destination queue non-empty OR output FIFO non-empty.

Optional Feature:
GSAU_PERF_CNT_EN:
- When defined, adds 32-bit saturating output counters, all cleared by RST only:
  - perf_issued: SA issues.
  - perf_credit_stall: cycles in READY with a compute instruction blocked on credits = 0.
  - perf_sa_stall: cycles in READY blocked on sa_fifo_has_space = 0.
  - perf_wb_stall: cycles with wb_valid = 1 and wb_ready = 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Assert RST for 3 cycles mid-transfer, then release -> every output holds its reset value, credits = DEPTH (8), FSM in IDLE.
2. Apply sb vdst = 8'h42, weight = 0, together with veg data 0xCAFEBABE, with sa_fifo_has_space = 1 -> sa_in_valid high for one cycle at N+1 with data 0xCAFEBABE; credits = 7. Pulse sa_out_en with 0x1234 and wb_ready = 1 -> wb_valid with wbdst = 0x42, data = 0x1234; credits = 8.
3. Present data 5 cycles before the instruction, and separately the instruction before the data -> HAVE_DATA and HAVE_INSTR paths are both taken and both issue correctly.
4. Hold wb_ready = 0 and issue 9 compute instructions with result pulses -> first 8 issue; 9th waits in READY at credits = 0; wb_valid stays high. Raise wb_ready -> results drain in order (vdst 0..7), then the 9th issues.
5. Issue a weight-load, then pulse sa_out_en -> no destination queue push, err_orphan = 1, no wb_valid.
6. Apply flush in the same cycle as sa_out_en with 3 results buffered -> queues empty, credits = 8, wb_valid = 0, err_orphan unchanged.
